// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle MIPS controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_RTYPEEX = 5'd6,
    S_RTYPEWB = 5'd7,
    S_BEQEX   = 5'd8,
    S_BNEEX   = 5'd9,
    S_ADDIEX  = 5'd10,
    S_ANDIEX  = 5'd11,
    S_ORIEX   = 5'd12,
    S_IWB     = 5'd13,
    S_JEX     = 5'd14,
    S_JALEX   = 5'd15
  } state_t;

  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;

  localparam logic [2:0] c_alu_add   = 3'b000;
  localparam logic [2:0] c_alu_sub   = 3'b001;
  localparam logic [2:0] c_alu_funct = 3'b010;
  localparam logic [2:0] c_alu_and   = 3'b011;
  localparam logic [2:0] c_alu_or    = 3'b100;

  localparam logic [1:0] c_srcb_reg   = 2'b00;
  localparam logic [1:0] c_srcb_four  = 2'b01;
  localparam logic [1:0] c_srcb_imm   = 2'b10;
  localparam logic [1:0] c_srcb_immsh = 2'b11;

  localparam logic [1:0] c_pc_alu    = 2'b00;
  localparam logic [1:0] c_pc_branch = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;

  localparam logic [1:0] c_rd_rt  = 2'b00;
  localparam logic [1:0] c_rd_rd  = 2'b01;
  localparam logic [1:0] c_rd_r31 = 2'b10;

  localparam logic [1:0] c_m2r_alu = 2'b00;
  localparam logic [1:0] c_m2r_mem = 2'b01;
  localparam logic [1:0] c_m2r_pc  = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       branch;
    logic       bne;
    logic       alusrca;
    logic       iord;
    logic       extop;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [2:0] aluop;
  } ctrl_t;

  // The extended opcodes are only legal when the build enables them.
  function automatic logic op_supported(input logic [5:0] op, input logic ext);
    case (op)
      c_op_lw, c_op_sw, c_op_rtype, c_op_beq, c_op_addi, c_op_j:
        op_supported = 1'b1;
      c_op_bne, c_op_andi, c_op_ori, c_op_jal:
        op_supported = ext;
      default:
        op_supported = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/maindec_ctrl_rom.sv
// ============================================================================
// Module   : maindec_ctrl_rom
// Purpose  : Combinational state-to-control-word map for the main decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maindec_ctrl_rom
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // Write enables are qualified by memready in the top level.
        ctrl.alusrcb = c_srcb_four;
        ctrl.aluop   = c_alu_add;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = c_srcb_immsh;
        ctrl.aluop   = c_alu_add;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = c_srcb_imm;
        ctrl.aluop   = c_alu_add;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = c_m2r_mem;
        ctrl.regdst   = c_rd_rt;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = c_srcb_reg;
        ctrl.aluop   = c_alu_funct;
      end
      S_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = c_rd_rd;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = c_alu_sub;
        ctrl.pcsrc   = c_pc_branch;
        ctrl.branch  = 1'b1;
      end
      S_BNEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = c_alu_sub;
        ctrl.pcsrc   = c_pc_branch;
        ctrl.bne     = 1'b1;
      end
      S_ANDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = c_srcb_imm;
        ctrl.extop   = 1'b1;
        ctrl.aluop   = c_alu_and;
      end
      S_ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = c_srcb_imm;
        ctrl.extop   = 1'b1;
        ctrl.aluop   = c_alu_or;
      end
      S_IWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = c_pc_jump;
      end
      S_JALEX: begin
        // PC already holds PC+4 here, so the link value is valid this cycle.
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsrc    = c_pc_jump;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = c_rd_r31;
        ctrl.memtoreg = c_m2r_pc;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/maindec_mc.sv
// ============================================================================
// Module   : maindec_mc
// Purpose  : Multi-cycle MIPS main decoder FSM with memory wait handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maindec_mc
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int EXT_OPS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       branch,
  output logic       bne,
  output logic       alusrca,
  output logic       iord,
  output logic       extop,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [4:0] state_o
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_rom;
  logic   w_memready;
  logic   w_ext;
  logic   w_legal;
  logic   w_fetch_ok;

  assign w_memready = (MEM_WAIT != 0) ? memready : 1'b1;
  assign w_ext      = (EXT_OPS != 0);
  assign w_legal    = op_supported(op, w_ext);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: if (w_memready) w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_FETCH;
        if (w_legal) begin
          case (op)
            c_op_lw, c_op_sw: w_next = S_MEMADR;
            c_op_rtype:       w_next = S_RTYPEEX;
            c_op_beq:         w_next = S_BEQEX;
            c_op_bne:         w_next = S_BNEEX;
            c_op_addi:        w_next = S_ADDIEX;
            c_op_andi:        w_next = S_ANDIEX;
            c_op_ori:         w_next = S_ORIEX;
            c_op_j:           w_next = S_JEX;
            c_op_jal:         w_next = S_JALEX;
            default:          w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (op == c_op_lw)      w_next = S_MEMRD;
        else if (op == c_op_sw) w_next = S_MEMWR;
        else                    w_next = S_FETCH;
      end
      S_MEMRD:   if (w_memready) w_next = S_MEMWB;
      S_MEMWR:   if (w_memready) w_next = S_FETCH;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX: w_next = S_IWB;
      default:   w_next = S_FETCH;
    endcase
  end

  maindec_ctrl_rom u_rom (
    .state (r_state),
    .ctrl  (w_rom)
  );

  // Fetch writes wait for the instruction word; reset kills every write.
  assign w_fetch_ok = (r_state != S_FETCH) || w_memready;

  assign pcwrite  = !reset && w_rom.pcwrite && w_fetch_ok;
  assign irwrite  = !reset && w_rom.irwrite && w_fetch_ok;
  assign memwrite = !reset && w_rom.memwrite;
  assign regwrite = !reset && w_rom.regwrite;
  assign branch   = !reset && w_rom.branch;
  assign bne      = !reset && w_rom.bne;

  assign alusrca  = w_rom.alusrca;
  assign iord     = w_rom.iord;
  assign extop    = w_rom.extop;
  assign alusrcb  = w_rom.alusrcb;
  assign pcsrc    = w_rom.pcsrc;
  assign regdst   = w_rom.regdst;
  assign memtoreg = w_rom.memtoreg;
  assign aluop    = w_rom.aluop;

  assign illegal  = (r_state == S_DECODE) && !w_legal;
  assign state_o  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_maindec_mc.sv
// ============================================================================
// Module   : tb_maindec_mc
// Purpose  : Self-checking bench for maindec_mc across three build variants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maindec_mc;
  import mips_ctrl_pkg::*;

  typedef state_t sq_t[$];

  localparam int MW [3] = '{0, 1, 1};
  localparam int EX [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op_v [3];
  logic        mr_v [3];
  logic [25:0] obs  [3];
  int          idx  [3];
  bit          chk  [3];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcwrite, memwrite, irwrite, regwrite, branch, bne;
    logic       alusrca, iord, extop, illegal;
    logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
    logic [2:0] aluop;
    logic [4:0] state_o;

    maindec_mc #(.MEM_WAIT(g == 0 ? 0 : 1), .EXT_OPS(g == 2 ? 0 : 1)) u_dut (
      .clk(clk), .reset(reset), .op(op_v[g]), .memready(mr_v[g]),
      .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite),
      .regwrite(regwrite), .branch(branch), .bne(bne), .alusrca(alusrca),
      .iord(iord), .extop(extop), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .regdst(regdst), .memtoreg(memtoreg), .aluop(aluop),
      .illegal(illegal), .state_o(state_o)
    );

    assign obs[g] = {pcwrite, memwrite, irwrite, regwrite, branch, bne,
                     alusrca, iord, extop, alusrcb, pcsrc, regdst, memtoreg,
                     aluop, illegal, state_o};
  end

  // Reference model: an instruction is an ordered list of phases.
  function automatic bit legal(logic [5:0] op, int ext);
    bit base, extd;
    base = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    extd = (op == 6'b000101) || (op == 6'b001100) || (op == 6'b001101) ||
           (op == 6'b000011);
    return base || (extd && ext != 0);
  endfunction

  function automatic sq_t path(logic [5:0] op, int ext);
    sq_t p;
    p = {S_FETCH, S_DECODE};
    if (legal(op, ext)) begin
      case (op)
        6'b100011: p = {p, S_MEMADR, S_MEMRD, S_MEMWB};
        6'b101011: p = {p, S_MEMADR, S_MEMWR};
        6'b000000: p = {p, S_RTYPEEX, S_RTYPEWB};
        6'b000100: p = {p, S_BEQEX};
        6'b000101: p = {p, S_BNEEX};
        6'b001000: p = {p, S_ADDIEX, S_IWB};
        6'b001100: p = {p, S_ANDIEX, S_IWB};
        6'b001101: p = {p, S_ORIEX, S_IWB};
        6'b000010: p = {p, S_JEX};
        6'b000011: p = {p, S_JALEX};
        default:   p = {S_FETCH, S_DECODE};
      endcase
    end
    return p;
  endfunction

  function automatic logic [25:0] exp_vec(int k);
    sq_t        p;
    state_t     ph;
    logic       mr, pcw, mw, irw, rw, br, bn, sa, io, ex, ill;
    logic [1:0] sb, pcs, rd, m2r;
    logic [2:0] alu;
    p  = path(op_v[k], EX[k]);
    ph = p[idx[k]];
    mr = (MW[k] == 0) ? 1'b1 : mr_v[k];
    {pcw, mw, irw, rw, br, bn, sa, io, ex} = '0;
    {sb, pcs, rd, m2r} = '0;
    alu = 3'b000;
    case (ph)
      S_FETCH:   begin sb = 2'b01; pcw = mr; irw = mr; end
      S_DECODE:  sb = 2'b11;
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin rw = 1; m2r = 2'b01; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_RTYPEEX: begin sa = 1; alu = 3'b010; end
      S_RTYPEWB: begin rw = 1; rd = 2'b01; end
      S_BEQEX:   begin sa = 1; alu = 3'b001; pcs = 2'b01; br = 1; end
      S_BNEEX:   begin sa = 1; alu = 3'b001; pcs = 2'b01; bn = 1; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_ANDIEX:  begin sa = 1; sb = 2'b10; ex = 1; alu = 3'b011; end
      S_ORIEX:   begin sa = 1; sb = 2'b10; ex = 1; alu = 3'b100; end
      S_IWB:     rw = 1;
      S_JEX:     begin pcw = 1; pcs = 2'b10; end
      S_JALEX:   begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      default:   ;
    endcase
    ill = (ph == S_DECODE) && !legal(op_v[k], EX[k]);
    if (reset) {pcw, mw, irw, rw, br, bn} = '0;
    return {pcw, mw, irw, rw, br, bn, sa, io, ex, sb, pcs, rd, m2r, alu, ill, 5'(ph)};
  endfunction

  task automatic advance();
    for (int k = 0; k < 3; k++) begin
      sq_t    p;
      state_t ph;
      logic   mr;
      p  = path(op_v[k], EX[k]);
      ph = p[idx[k]];
      mr = (MW[k] == 0) ? 1'b1 : mr_v[k];
      if (reset) idx[k] = 0;
      else if (!((ph == S_FETCH || ph == S_MEMRD || ph == S_MEMWR) && !mr)) begin
        idx[k]++;
        if (idx[k] >= p.size()) idx[k] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 10))
      0: return 6'b100011;  1: return 6'b101011;  2: return 6'b000000;
      3: return 6'b000100;  4: return 6'b000101;  5: return 6'b001000;
      6: return 6'b001100;  7: return 6'b001101;  8: return 6'b000010;
      9: return 6'b000011;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 3; k++) begin op_v[k] = rand_op(); mr_v[k] = 1'($urandom); end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL reset dut%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
        end
      end
      step();
    end
    reset = 1'b0;
  endtask

  task automatic test_lw_nowait();
    do_reset();
    op_v[0] = 6'b100011;
    for (int c = 0; c < 6; c++) begin
      mr_v[0] = 1'($urandom);
      @(negedge clk);
      nvec++;
      if (obs[0] !== exp_vec(0)) begin
        nerr++;
        $display("FAIL lw_nowait cyc%0d: got %h want %h", c, obs[0], exp_vec(0));
      end
      step();
    end
  endtask

  task automatic test_sw_wait();
    logic mrs [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    int   nmw = 0;
    do_reset();
    op_v[1] = 6'b101011;
    for (int c = 0; c < 10; c++) begin
      mr_v[1] = mrs[c];
      @(negedge clk);
      nvec++;
      if (obs[1] !== exp_vec(1)) begin
        nerr++;
        $display("FAIL sw_wait cyc%0d: got %h want %h", c, obs[1], exp_vec(1));
      end
      if (obs[1][24] === 1'b1) nmw++;
      step();
    end
    nvec++;
    if (nmw !== 4) begin
      nerr++;
      $display("FAIL sw_wait_memwrite_cycles: got %0d want 4", nmw);
    end
  endtask

  task automatic test_jal();
    do_reset();
    op_v[0] = 6'b000011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nvec++;
      if (obs[0] !== exp_vec(0)) begin
        nerr++;
        $display("FAIL jal cyc%0d: got %h want %h", c, obs[0], exp_vec(0));
      end
      step();
    end
  endtask

  task automatic test_bne_ori();
    logic [5:0] ops [2] = '{6'b000101, 6'b001101};
    do_reset();
    mr_v[1] = 1'b1;
    foreach (ops[i]) begin
      op_v[1] = ops[i];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        nvec++;
        if (obs[1] !== exp_vec(1)) begin
          nerr++;
          $display("FAIL bne_ori op%b cyc%0d: got %h want %h", ops[i], c, obs[1], exp_vec(1));
        end
        step();
        if (idx[1] == 0) break;
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    op_v[0] = 6'b111111;
    op_v[2] = 6'b001100;
    mr_v[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k += 2) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL illegal dut%0d cyc%0d: got %h want %h", k, c, obs[k], exp_vec(k));
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op_v[1] = 6'b101011;
    mr_v[1] = 1'b1;
    for (int c = 0; c < 3; c++) step();
    mr_v[1] = 1'b0;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    nvec++;
    if (obs[1] !== exp_vec(1) || obs[1][24] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_in_memwr: got %h want %h", obs[1], exp_vec(1));
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if (obs[1][4:0] !== 5'(S_FETCH) || obs[1] !== exp_vec(1)) begin
      nerr++;
      $display("FAIL reset_mid_release: got %h want %h", obs[1], exp_vec(1));
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 3; k++) begin
        if (idx[k] == 0) op_v[k] = rand_op();
        mr_v[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (obs[k] !== exp_vec(k)) begin
          nerr++;
          $display("FAIL random dut%0d cyc%0d op%b: got %h want %h", k, c, op_v[k], obs[k], exp_vec(k));
        end
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op_v[k] = 6'b000000;
      mr_v[k] = 1'b1;
      idx[k]  = 0;
      chk[k]  = 1'b1;
    end
    step();
    test_reset();
    test_lw_nowait();
    test_sw_wait();
    test_jal();
    test_bne_ori();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
